// File: rtl/unary_add_driver.sv
// Sequencing master for the serial unary adder: streams two 3-bit operands as unary
// pulse trains, then counts the adder's returned dout pulses back into a binary sum.
module unary_add_driver #(
  parameter int DRAIN_MAX = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] a_val,
  input  logic [2:0] b_val,
  output logic       busy,
  output logic       done,
  output logic [3:0] sum_val,
  output logic       carry,
  output logic       err,
  output logic       A,
  output logic       B,
  output logic       en,
  output logic       read_or_write,
  input  logic       dout,
  input  logic       C
);

  localparam int DW = $clog2(DRAIN_MAX + 1);
  localparam logic [DW-1:0] LP_DRAIN_MAX = DW'(DRAIN_MAX);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEND  = 3'd1,
    S_FLUSH = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        r_state;
  logic [2:0]    r_a;
  logic [2:0]    r_b;
  logic [2:0]    r_m;
  logic [2:0]    r_idx;
  logic          r_flush;
  logic [DW-1:0] r_drain;
  logic [3:0]    r_cnt;
  logic          r_cacc;

  logic [2:0]    w_m;
  logic [3:0]    w_cnt_inc;

  assign w_m       = (a_val > b_val) ? a_val : b_val;
  assign w_cnt_inc = r_cnt + 4'd1;

  // Sequencer FSM; every adder-facing output is set for the cycle being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_a           <= 3'd0;
      r_b           <= 3'd0;
      r_m           <= 3'd0;
      r_idx         <= 3'd0;
      r_flush       <= 1'b0;
      r_drain       <= '0;
      r_cnt         <= 4'd0;
      r_cacc        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      sum_val       <= 4'd0;
      carry         <= 1'b0;
      err           <= 1'b0;
      A             <= 1'b0;
      B             <= 1'b0;
      en            <= 1'b0;
      read_or_write <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a           <= a_val;
            r_b           <= b_val;
            r_m           <= w_m;
            r_idx         <= 3'd1;
            r_flush       <= 1'b0;
            r_drain       <= '0;
            r_cnt         <= 4'd0;
            r_cacc        <= 1'b0;
            busy          <= 1'b1;
            en            <= 1'b1;
            read_or_write <= 1'b0;
            A             <= (a_val != 3'd0);
            B             <= (b_val != 3'd0);
            r_state       <= (w_m == 3'd0) ? S_FLUSH : S_SEND;
          end
        end
        S_SEND: begin
          r_cacc <= r_cacc | C;
          if (r_idx == r_m) begin
            A       <= 1'b0;
            B       <= 1'b0;
            r_flush <= 1'b0;
            r_state <= S_FLUSH;
          end else begin
            A     <= (r_idx < r_a);
            B     <= (r_idx < r_b);
            r_idx <= r_idx + 3'd1;
          end
        end
        S_FLUSH: begin
          r_cacc <= r_cacc | C;
          if (r_flush) begin
            read_or_write <= 1'b1;
            r_drain       <= DW'(1);
            r_state       <= S_DRAIN;
          end else begin
            r_flush <= 1'b1;
          end
        end
        S_DRAIN: begin
          // First drain cycle still shows the adder's stale read-phase dout
          if (r_drain == DW'(1)) begin
            r_cacc  <= r_cacc | C;
            r_drain <= r_drain + DW'(1);
          end else if (!dout || (r_drain == LP_DRAIN_MAX)) begin
            sum_val       <= dout ? w_cnt_inc : r_cnt;
            err           <= dout;
            carry         <= r_cacc;
            done          <= 1'b1;
            busy          <= 1'b0;
            en            <= 1'b0;
            read_or_write <= 1'b0;
            r_state       <= S_DONE;
          end else begin
            r_cnt   <= w_cnt_inc;
            r_drain <= r_drain + DW'(1);
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy          <= 1'b0;
          done          <= 1'b0;
          en            <= 1'b0;
          read_or_write <= 1'b0;
          A             <= 1'b0;
          B             <= 1'b0;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule
